keypad_scanner: RTL

Matrix keypad reader that sits beside the processor on the board top level. It is the input-side counterpart to the multiplexed seven-segment output path. It scans a 4x4 active-low keypad row by row, synchronises and debounces the column returns, and emits one code per distinct press. An optional decimal-entry accumulator builds a 13-bit operand, in the same width as the SSD number path, for the processor to consume.

---
 rtl/keypad_pkg.sv | 47 ++++
 rtl/keypad_entry.sv | 51 +++++
 rtl/keypad_scanner.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared constants and encodings for the matrix keypad reader.
// Holds the operand width and limit, the special key codes, the
// RELEASED/PRESSED state encoding, the frame class encoding and the
// position-to-code lookup used by the scanner.
package keypad_pkg;

    localparam int NUM_W   = 13;
    localparam int NUM_MAX = 8191;

    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    localparam logic [0:0] ST_RELEASED = 1'b0;
    localparam logic [0:0] ST_PRESSED  = 1'b1;

    typedef enum logic [1:0] {
        CLS_NONE  = 2'd0,
        CLS_KEY   = 2'd1,
        CLS_MULTI = 2'd2
    } frame_class_t;

    // Map a frame bit position (row*4 + col) to its key code.
    // Layout: [1 2 3 A] [4 5 6 B] [7 8 9 C] [* 0 # D]
    function automatic logic [3:0] keyCodeOf(input logic [3:0] pos);
        logic [3:0] code;
        case (pos)
            4'd0:    code = 4'd1;
            4'd1:    code = 4'd2;
            4'd2:    code = 4'd3;
            4'd3:    code = 4'd10;
            4'd4:    code = 4'd4;
            4'd5:    code = 4'd5;
            4'd6:    code = 4'd6;
            4'd7:    code = 4'd11;
            4'd8:    code = 4'd7;
            4'd9:    code = 4'd8;
            4'd10:   code = 4'd9;
            4'd11:   code = 4'd12;
            4'd12:   code = KEY_STAR;
            4'd13:   code = 4'd0;
            4'd14:   code = KEY_HASH;
            default: code = 4'd13;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_entry.sv
// Decimal-entry accumulator for the keypad reader.
// Digits shift into a 13-bit operand (num*10+d), '*' clears it and '#'
// commits it with a one-cycle num_valid pulse. A digit that would push
// the operand past NUM_MAX is accepted as a key but leaves num alone.
// The strobe and code arrive as next-state values from the scanner so
// that num changes on the same edge as the registered key_valid.
module keypad_entry
    import keypad_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_keyValid,
    input  logic [3:0]       i_keyCode,
    output logic [NUM_W-1:0] o_num,
    output logic             o_numValid
);

    logic [NUM_W-1:0] r_num;
    logic             r_numValid;
    logic [16:0]      w_prod;
    logic             w_isDigit;

    // Candidate operand computed wide enough that overflow is visible.
    always_comb begin
        w_prod    = (17'(r_num) * 17'd10) + 17'(i_keyCode);
        w_isDigit = (i_keyCode <= 4'd9);
    end

    // Update the operand and commit pulse on each accepted key.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_num      <= '0;
            r_numValid <= 1'b0;
        end else begin
            r_numValid <= i_keyValid && (i_keyCode == KEY_HASH);
            if (i_keyValid) begin
                if (w_isDigit) begin
                    if (w_prod <= 17'(NUM_MAX)) begin
                        r_num <= w_prod[NUM_W-1:0];
                    end
                end else if (i_keyCode == KEY_STAR) begin
                    r_num <= '0;
                end
            end
        end
    end

    assign o_num      = r_num;
    assign o_numValid = r_numValid;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with debounce and press detection.
// Rows are driven one at a time; the synchronised column returns are
// captured at the end of each row slot into a 16-bit frame image. Each
// completed frame is classified as NONE, KEY(code) or MULTI, and a class
// must repeat for DEBOUNCE frames before the press detector acts on it.
// Optional macro KEYPAD_ENTRY_EN builds the decimal-entry accumulator;
// without it num and num_valid are tied to 0.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
)(
    input  logic             clk,
    input  logic             rst,
    output logic [3:0]       row,
    input  logic [3:0]       col,
    output logic             key_valid,
    output logic [3:0]       key_code,
    output logic [NUM_W-1:0] num,
    output logic             num_valid
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE);

    logic [3:0]       r_colMeta;
    logic [3:0]       r_colSync;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_rowIdx;
    logic [15:0]      r_frame;
    frame_class_t     r_prevCls;
    logic [3:0]       r_prevCode;
    logic [CNT_W-1:0] r_cnt;
    logic [0:0]       r_state;
    logic             r_keyValid;
    logic [3:0]       r_keyCode;

    logic             w_sampleTick;
    logic             w_frameClose;
    logic [15:0]      w_frameNext;
    logic [4:0]       w_hits;
    logic [3:0]       w_pos;
    frame_class_t     w_cls;
    logic [3:0]       w_code;
    logic             w_same;
    logic [CNT_W-1:0] w_cntNext;
    logic             w_stable;
    logic             w_accept;
    logic             w_release;

    // Two-flop synchroniser for the asynchronous column returns.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_colMeta <= 4'hF;
            r_colSync <= 4'hF;
        end else begin
            r_colMeta <= col;
            r_colSync <= r_colMeta;
        end
    end

    assign w_sampleTick = (r_div == DIV_LAST);
    assign w_frameClose = w_sampleTick && (r_rowIdx == 2'd3);

    // Row slot divider; the row index advances after its slot is sampled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_div    <= '0;
            r_rowIdx <= 2'd0;
        end else if (w_sampleTick) begin
            r_div    <= '0;
            r_rowIdx <= r_rowIdx + 2'd1;
        end else begin
            r_div    <= r_div + DIV_W'(1);
        end
    end

    assign row = ~(4'b0001 << r_rowIdx);

    // Frame image including the row being sampled this cycle.
    always_comb begin
        w_frameNext = r_frame;
        w_frameNext[{r_rowIdx, 2'b00} +: 4] = r_colSync;
    end

    // Store each row's columns into the frame image at its sample point.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_frame <= 16'hFFFF;
        end else if (w_sampleTick) begin
            r_frame <= w_frameNext;
        end
    end

    // Classify the completed frame by how many keys read as pressed.
    always_comb begin
        w_hits = '0;
        w_pos  = '0;
        for (int i = 0; i < 16; i++) begin
            if (!w_frameNext[i]) begin
                w_hits = w_hits + 5'd1;
                w_pos  = 4'(i);
            end
        end
        w_cls  = CLS_NONE;
        w_code = '0;
        if (w_hits == 5'd1) begin
            w_cls  = CLS_KEY;
            w_code = keyCodeOf(w_pos);
        end else if (w_hits > 5'd1) begin
            w_cls  = CLS_MULTI;
        end
    end

    // Repeat counter: a class that matches the previous frame counts up
    // to DEBOUNCE and holds there, any change starts again at one.
    always_comb begin
        w_same = (w_cls == r_prevCls) && (w_code == r_prevCode);
        if (w_same) begin
            w_cntNext = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + CNT_W'(1));
        end else begin
            w_cntNext = CNT_W'(1);
        end
        w_stable = w_frameClose && (w_cntNext == CNT_MAX);
    end

    // Remember the last frame class and its repeat count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_prevCls  <= CLS_NONE;
            r_prevCode <= '0;
            r_cnt      <= '0;
        end else if (w_frameClose) begin
            r_prevCls  <= w_cls;
            r_prevCode <= w_code;
            r_cnt      <= w_cntNext;
        end
    end

    // Press detection: only a stable single key from RELEASED is an event,
    // and only a stable empty frame re-arms it; MULTI is ignored.
    always_comb begin
        w_accept  = w_stable && (r_state == ST_RELEASED) && (w_cls == CLS_KEY);
        w_release = w_stable && (r_state == ST_PRESSED) && (w_cls == CLS_NONE);
    end

    // Press state machine with registered key outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_RELEASED;
            r_keyValid <= 1'b0;
            r_keyCode  <= '0;
        end else begin
            r_keyValid <= w_accept;
            if (w_accept) begin
                r_keyCode <= w_code;
                r_state   <= ST_PRESSED;
            end else if (w_release) begin
                r_state   <= ST_RELEASED;
            end
        end
    end

    assign key_valid = r_keyValid;
    assign key_code  = r_keyCode;

`ifdef KEYPAD_ENTRY_EN
    keypad_entry u_entry (
        .clk        (clk),
        .rst        (rst),
        .i_keyValid (w_accept),
        .i_keyCode  (w_code),
        .o_num      (num),
        .o_numValid (num_valid)
    );
`else
    assign num       = '0;
    assign num_valid = 1'b0;
`endif

endmodule
